// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with an optional return-address stack.
// The PC updates on INC / BR_REL / JMP_ABS / CALL / RET when pc_write is high.
// Optional feature macro: PC_RET_STACK_EN. When it is defined, a circular
// LIFO of STACK_DEPTH entries backs CALL/RET. When it is undefined, CALL
// behaves as BR_REL, RET behaves as INC, and the stack status is tied off.
// All outputs come straight from registers or are decoded from registers only.
module pc_sequencer #(
  parameter int WIDTH       = 12,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_PC    = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pc_write,
  input  logic [2:0]                         pc_op,
  input  logic [WIDTH-1:0]                   pc_offset,
  input  logic [WIDTH-1:0]                   pc_target,
  output logic [WIDTH-1:0]                   pc_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               stack_err,
  input  logic                               err_clr
);

  localparam int CW = $clog2(STACK_DEPTH+1);

  localparam logic [2:0] OP_INC     = 3'b000;
  localparam logic [2:0] OP_BR_REL  = 3'b001;
  localparam logic [2:0] OP_JMP_ABS = 3'b010;
  localparam logic [2:0] OP_CALL    = 3'b011;
  localparam logic [2:0] OP_RET     = 3'b100;

  localparam logic [WIDTH-1:0] PC_INIT = WIDTH'(RESET_PC);

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_next_s;
  logic [WIDTH-1:0] seq_s;
  logic [WIDTH-1:0] rel_s;

  // Sequential and relative targets wrap modulo 2^WIDTH with no flag.
  assign seq_s  = pc_r + WIDTH'(1'b1);
  assign rel_s  = seq_s + pc_offset;
  assign pc_out = pc_r;

  // PC register; reset forces RESET_PC immediately, independent of the clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= PC_INIT;
    end else begin
      pc_r <= pc_next_s;
    end
  end

`ifdef PC_RET_STACK_EN

  localparam int PW = $clog2(STACK_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(STACK_DEPTH-1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STACK_DEPTH);

  // Circular buffer: top_ptr_r names the newest entry. A push on a full stack
  // lands on the oldest slot, which gives the overwrite-oldest behaviour for free.
  logic [WIDTH-1:0] stack_mem_r [STACK_DEPTH];
  logic [PW-1:0]    top_ptr_r;
  logic [PW-1:0]    push_ptr_s;
  logic [PW-1:0]    pop_ptr_s;
  logic [CW-1:0]    count_r;
  logic             err_r;
  logic             push_s;
  logic             pop_s;
  logic             err_set_s;
  logic             full_s;
  logic             empty_s;

  assign full_s     = (count_r == CNT_MAX);
  assign empty_s    = (count_r == {CW{1'b0}});
  assign push_ptr_s = (top_ptr_r == PTR_LAST)   ? {PW{1'b0}} : top_ptr_r + PW'(1'b1);
  assign pop_ptr_s  = (top_ptr_r == {PW{1'b0}}) ? PTR_LAST   : top_ptr_r - PW'(1'b1);

  // Next-PC selection plus push/pop/error requests for the stack.
  always_comb begin
    pc_next_s = pc_r;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    err_set_s = 1'b0;
    if (pc_write) begin
      case (pc_op)
        OP_INC:     pc_next_s = seq_s;
        OP_BR_REL:  pc_next_s = rel_s;
        OP_JMP_ABS: pc_next_s = pc_target;
        OP_CALL: begin
          pc_next_s = rel_s;
          push_s    = 1'b1;
          err_set_s = full_s;
        end
        OP_RET: begin
          if (empty_s) begin
            pc_next_s = seq_s;
            err_set_s = 1'b1;
          end else begin
            pc_next_s = stack_mem_r[top_ptr_r];
            pop_s     = 1'b1;
          end
        end
        default:    pc_next_s = seq_s;
      endcase
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Stack bookkeeping: pointer, occupancy and the sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_ptr_r <= {PW{1'b0}};
      count_r   <= {CW{1'b0}};
      err_r     <= 1'b0;
    end else begin
      if (push_s) begin
        top_ptr_r <= push_ptr_s;
        if (!full_s) begin
          count_r <= count_r + CW'(1'b1);
        end
      end else if (pop_s) begin
        top_ptr_r <= pop_ptr_s;
        count_r   <= count_r - CW'(1'b1);
      end
      if (err_clr) begin
        err_r <= 1'b0;
      end else if (err_set_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Stack storage; entries beyond the count are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      stack_mem_r[push_ptr_s] <= seq_s;
    end
  end

  assign stack_count = count_r;
  assign stack_full  = full_s;
  assign stack_empty = empty_s;
  assign stack_err   = err_r;

`else

  logic unused_err_clr_s;
  assign unused_err_clr_s = err_clr;

  // Next-PC selection without a stack: CALL is a relative branch, RET an increment.
  always_comb begin
    pc_next_s = pc_r;
    if (pc_write) begin
      case (pc_op)
        OP_INC:     pc_next_s = seq_s;
        OP_BR_REL:  pc_next_s = rel_s;
        OP_JMP_ABS: pc_next_s = pc_target;
        OP_CALL:    pc_next_s = rel_s;
        OP_RET:     pc_next_s = seq_s;
        default:    pc_next_s = seq_s;
      endcase
    end else begin
      pc_next_s = pc_r;
    end
  end

  assign stack_count = {CW{1'b0}};
  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
  assign stack_err   = 1'b0;

`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// operations compared against a queue-based reference model. The model follows
// PC_RET_STACK_EN the same way the design does.
module tb_pc_sequencer;

  localparam int W = 12;
  localparam int D = 4;

  logic          clk;
  logic          reset;
  logic          pc_write;
  logic [2:0]    pc_op;
  logic [W-1:0]  pc_offset;
  logic [W-1:0]  pc_target;
  logic [W-1:0]  pc_out;
  logic [2:0]    stack_count;
  logic          stack_full;
  logic          stack_empty;
  logic          stack_err;
  logic          err_clr;

  pc_sequencer #(.WIDTH(W), .STACK_DEPTH(D), .RESET_PC(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_write    (pc_write),
    .pc_op       (pc_op),
    .pc_offset   (pc_offset),
    .pc_target   (pc_target),
    .pc_out      (pc_out),
    .stack_count (stack_count),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: the PC, the return stack as a queue, and the error flag.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stack[$];
  logic         m_err;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 12'h000;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] op, input logic wr, input logic [W-1:0] off,
                            input logic [W-1:0] tgt, input logic clr);
    logic [W-1:0] seq;
    logic [W-1:0] rel;
    seq = m_pc + 12'd1;
    rel = seq + off;
    if (wr) begin
      case (op)
        3'd1: m_pc = rel;
        3'd2: m_pc = tgt;
        3'd3: begin
`ifdef PC_RET_STACK_EN
          m_stack.push_back(seq);
          if (m_stack.size() > D) begin
            m_stack.delete(0);
            m_err = 1'b1;
          end
`endif
          m_pc = rel;
        end
        3'd4: begin
`ifdef PC_RET_STACK_EN
          if (m_stack.size() == 0) begin
            m_pc  = seq;
            m_err = 1'b1;
          end else begin
            m_pc = m_stack.pop_back();
          end
`else
          m_pc = seq;
`endif
        end
        default: m_pc = seq;
      endcase
    end
    if (clr) m_err = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = m_stack.size();
    check_value({tag, ".pc"},    pc_out,      m_pc);
    check_value({tag, ".count"}, stack_count, sz);
    check_value({tag, ".full"},  stack_full,  (sz == D) ? 1 : 0);
    check_value({tag, ".empty"}, stack_empty, (sz == 0) ? 1 : 0);
    check_value({tag, ".err"},   stack_err,   m_err);
  endtask

  // Drive one operation, clock it, advance the model, and compare after the edge.
  task automatic do_op(input string tag, input logic [2:0] op, input logic wr,
                       input logic [W-1:0] off, input logic [W-1:0] tgt, input logic clr);
    pc_op     = op;
    pc_write  = wr;
    pc_offset = off;
    pc_target = tgt;
    err_clr   = clr;
    @(posedge clk);
    model_step(op, wr, off, tgt, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset     = 1'b1;
    pc_write  = 1'b0;
    pc_op     = 3'd0;
    pc_offset = 12'h000;
    pc_target = 12'h000;
    err_clr   = 1'b0;
    model_reset();

    // Reset state held across clock edges.
    #12;
    check_value("rst.pc",    pc_out,      32'h0);
    check_value("rst.count", stack_count, 32'h0);
    check_value("rst.empty", stack_empty, 32'h1);
    check_value("rst.full",  stack_full,  32'h0);
    check_value("rst.err",   stack_err,   32'h0);
    #1 reset = 1'b0;

    // Three increments then two held cycles.
    do_op("inc1", 3'd0, 1'b1, 12'h000, 12'h000, 1'b0);
    do_op("inc2", 3'd0, 1'b1, 12'h000, 12'h000, 1'b0);
    do_op("inc3", 3'd0, 1'b1, 12'h000, 12'h000, 1'b0);
    check_value("inc3.const", pc_out, 32'h3);
    do_op("hold1", 3'd2, 1'b0, 12'h123, 12'h456, 1'b0);
    do_op("hold2", 3'd3, 1'b0, 12'h010, 12'h456, 1'b0);
    check_value("hold.const", pc_out, 32'h3);

    // Wrap at the top of the address space and a negative branch.
    do_op("jmp_ffe", 3'd2, 1'b1, 12'h000, 12'hFFE, 1'b0);
    do_op("inc_fff", 3'd0, 1'b1, 12'h000, 12'h000, 1'b0);
    check_value("inc_fff.const", pc_out, 32'hFFF);
    do_op("inc_wrap", 3'd0, 1'b1, 12'h000, 12'h000, 1'b0);
    check_value("inc_wrap.const", pc_out, 32'h000);
    do_op("jmp_010", 3'd2, 1'b1, 12'h000, 12'h010, 1'b0);
    do_op("br_neg", 3'd1, 1'b1, 12'hFFC, 12'h000, 1'b0);
    check_value("br_neg.const", pc_out, 32'h00D);

    // Jump, call, return.
    do_op("jmp_020", 3'd2, 1'b1, 12'h000, 12'h020, 1'b0);
    do_op("jmp_5a5", 3'd2, 1'b1, 12'h000, 12'h5A5, 1'b0);
    check_value("jmp_5a5.const", pc_out, 32'h5A5);
    do_op("call", 3'd3, 1'b1, 12'h010, 12'h000, 1'b0);
    check_value("call.const", pc_out, 32'h5B6);
    do_op("ret", 3'd4, 1'b1, 12'h000, 12'h000, 1'b0);
`ifdef PC_RET_STACK_EN
    check_value("ret.const", pc_out, 32'h5A6);
`else
    check_value("ret.const", pc_out, 32'h5B7);
`endif

    // Five calls overflow a 4-deep stack; four returns come back LIFO.
    do_op("jmp_100", 3'd2, 1'b1, 12'h000, 12'h100, 1'b0);
    for (int i = 0; i < 5; i++) do_op("ovf_call", 3'd3, 1'b1, 12'h000, 12'h000, 1'b0);
`ifdef PC_RET_STACK_EN
    check_value("ovf.full",  stack_full,  32'h1);
    check_value("ovf.err",   stack_err,   32'h1);
    check_value("ovf.count", stack_count, 32'h4);
    for (int i = 0; i < 4; i++) begin
      do_op("lifo_ret", 3'd4, 1'b1, 12'h000, 12'h000, 1'b0);
      check_value("lifo.const", pc_out, 32'h105 - i);
    end
`endif
    do_op("clr1", 3'd0, 1'b0, 12'h000, 12'h000, 1'b1);

    // Return on an empty stack, then clear; then clear beating a same-cycle set.
    do_op("jmp_100b", 3'd2, 1'b1, 12'h000, 12'h100, 1'b0);
    do_op("ret_empty", 3'd4, 1'b1, 12'h000, 12'h000, 1'b0);
    check_value("ret_empty.const", pc_out, 32'h101);
`ifdef PC_RET_STACK_EN
    check_value("ret_empty.err", stack_err, 32'h1);
`endif
    do_op("err_clr", 3'd0, 1'b0, 12'h000, 12'h000, 1'b1);
    check_value("err_clr.const", stack_err, 32'h0);
    do_op("clr_wins", 3'd4, 1'b1, 12'h000, 12'h000, 1'b1);
    check_value("clr_wins.const", stack_err, 32'h0);

    // Randomized operations against the model.
    for (int i = 0; i < 400; i++) begin
      do_op("rand", 3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
            12'($urandom), 12'($urandom), ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end

    // Reset asserted between edges in the middle of a call sequence.
    do_op("pre_rst_jmp", 3'd2, 1'b1, 12'h000, 12'h300, 1'b0);
    do_op("pre_rst_call", 3'd3, 1'b1, 12'h004, 12'h000, 1'b0);
    do_op("pre_rst_call", 3'd3, 1'b1, 12'h004, 12'h000, 1'b0);
    pc_op    = 3'd3;
    pc_write = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_value("async_rst.pc",    pc_out,      32'h0);
    check_value("async_rst.count", stack_count, 32'h0);
    check_value("async_rst.empty", stack_empty, 32'h1);
    check_value("async_rst.err",   stack_err,   32'h0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    do_op("post_rst_inc", 3'd0, 1'b1, 12'h000, 12'h000, 1'b0);
    check_value("post_rst.const", pc_out, 32'h1);
    do_op("post_rst_call", 3'd3, 1'b1, 12'h000, 12'h000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 12, meaning the PC, offset and target width in bits.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, meaning the return-address stack entries (>=2).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning the PC value loaded on reset.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port pc_write, input, 1, the update enable; when low, all state holds.
REQ-007 SHALL have port pc_op, input, 3, the operation: 000 INC, 001 BR_REL, 010 JMP_ABS, 011 CALL, 100 RET, 101-111 treated as INC.
REQ-008 SHALL have port pc_offset, input, WIDTH, a signed two's-complement relative displacement.
REQ-009 SHALL have port pc_target, input, WIDTH, the absolute jump address.
REQ-010 SHALL have port pc_out, output, WIDTH, the registered current PC.
REQ-011 SHALL have port stack_count, output, $clog2(STACK_DEPTH+1), the valid stack entries.
REQ-012 SHALL have port stack_full / stack_empty, output, 1 each, asserted when count==STACK_DEPTH / count==0.
REQ-013 SHALL have port stack_err, output, 1, a sticky overflow/underflow flag.
REQ-014 SHALL have port err_clr, input, 1, a synchronous clear of stack_err.

Function
REQ-015 SHALL make all outputs registered or decoded from registers only; no combinational input-to-output path.
REQ-016 SHALL define seq = pc_out+1 and rel = pc_out+1+pc_offset, modulo 2^WIDTH (wrap silently, no flag).
REQ-017 SHALL, when pc_write=1, load next PC = INC:seq, BR_REL:rel, JMP_ABS:pc_target, CALL:rel, RET:top-of-stack; update latency is 1 cycle.
REQ-018 SHALL, on CALL, push seq onto the stack in the same cycle as the PC load.
REQ-019 SHALL, on CALL with stack full, discard the oldest entry (circular overwrite), keep count=STACK_DEPTH, and set stack_err.
REQ-020 SHALL, on RET, pop: PC <= top entry, count decrements.
REQ-021 SHALL, on RET with stack empty, load PC <= seq, keep count=0, and set stack_err.
REQ-022 SHALL, when pc_write=0, not push, pop or move the PC regardless of pc_op.
REQ-023 SHALL give err_clr priority over a same-cycle error set (err_clr wins); err_clr is independent of pc_write.
REQ-024 SHALL ignore stack entries beyond count; their contents are don't-care.

Reset
REQ-025 SHALL, while reset=1, asynchronously force pc_out=RESET_PC, stack_count=0, stack_empty=1, stack_full=0, stack_err=0.
REQ-026 SHALL, on reset asserted mid-CALL/RET, abandon the push/pop; the first edge after release performs normal operation.

Configuration
REQ-027 SHALL, with macro PC_RET_STACK_EN defined, implement the stack per REQ-018..REQ-021.
REQ-028 SHALL, without PC_RET_STACK_EN, instantiate no stack storage, execute CALL as BR_REL and RET as INC, and tie stack_count=0, stack_empty=1, stack_full=0, stack_err=0.

Verification
REQ-029 SHALL cover: reset, then 3 INC cycles with pc_write=1 -> pc_out 0,1,2,3; pc_write=0 for 2 cycles -> holds 3.
REQ-030 SHALL cover: pc_out=0xFFE, INC, INC -> 0xFFF, 0x000; pc_out=0x010, BR_REL offset=0xFFC (-4) -> 0x00D.
REQ-031 SHALL cover: pc_out=0x020, JMP_ABS target=0x5A5 -> 0x5A5; CALL offset=0x010 -> pc 0x5B6, stack top 0x5A6, count 1; RET -> 0x5A6, count 0.
REQ-032 SHALL cover: 5 CALLs with STACK_DEPTH=4 -> stack_full=1, stack_err=1, count 4; 4 RETs return the last 4 pushed addresses in LIFO order.
REQ-033 SHALL cover: RET on empty stack at pc 0x100 -> pc 0x101, stack_err=1; err_clr=1 one cycle -> stack_err=0.
REQ-034 SHALL cover: reset asserted between clock edges during a CALL sequence -> pc_out=RESET_PC, count 0 immediately, without waiting for an edge.
